// File: rtl/mcu_subsys_pkg.sv
// Shared types and constants for the MCU subsystem SRAM arbiter and its helpers.
package mcu_subsys_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic ARB_PORT_CPU = 1'b0;
    localparam logic ARB_PORT_DMA = 1'b1;

    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;
    localparam int MEM_SW = 4;

    typedef struct packed {
        logic              valid;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
        logic [MEM_SW-1:0] wstrb;
    } mem_req_t;

    function automatic mem_req_t sel_req(input logic sel, input mem_req_t req_cpu,
                                         input mem_req_t req_dma);
        return (sel == ARB_PORT_DMA) ? req_dma : req_cpu;
    endfunction

endpackage

// File: rtl/mcu_subsys_rr_pick.sv
// Two-requester round-robin picker: a lone requester wins, a tie goes to the port
// that did not complete last.
module mcu_subsys_rr_pick
    import mcu_subsys_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = ARB_PORT_CPU;
        case (req)
            2'b01:   grant = ARB_PORT_CPU;
            2'b10:   grant = ARB_PORT_DMA;
            2'b11:   grant = ~last;
            default: grant = ARB_PORT_CPU;
        endcase
    end

endmodule

// File: rtl/mcu_subsys_sram_arb.sv
// Arbiter sharing the single-port subsystem SRAM between the CPU (port 0) and the
// GNSS sample DMA (port 1), with a watchdog that completes unacknowledged accesses.
//
//   state    | meaning
//   ARB_IDLE | no access in flight; pick a winner from the current requests
//   ARB_BUSY | granted port's request forwarded to SRAM; wait for ready or watchdog
module mcu_subsys_sram_arb
    import mcu_subsys_pkg::*;
#(
    parameter int          TIMEOUT_CYC = 16,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_mem_valid,
    output logic        cpu_mem_ready,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic [31:0] cpu_mem_rdata,

    input  logic        dma_mem_valid,
    output logic        dma_mem_ready,
    input  logic [31:0] dma_mem_addr,
    input  logic [31:0] dma_mem_wdata,
    input  logic [3:0]  dma_mem_wstrb,
    output logic [31:0] dma_mem_rdata,

    output logic        sram_mem_valid,
    input  logic        sram_mem_ready,
    output logic [31:0] sram_mem_addr,
    output logic [31:0] sram_mem_wdata,
    output logic [3:0]  sram_mem_wstrb,
    input  logic [31:0] sram_mem_rdata,

    output logic        timeout_err
);

    localparam int              WD_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

    arb_state_t      state_q;
    logic            grant_q;
    logic            last_q;
    logic [WD_W-1:0] wd_cnt;

    mem_req_t    cpu_req;
    mem_req_t    dma_req;
    mem_req_t    gnt_req;
    logic        pick_grant;
    logic        busy;
    logic        wd_fire;
    logic        live;
    logic        done_ok;
    logic        done_to;
    logic [31:0] done_rdata;

    always_comb begin
        cpu_req.valid = cpu_mem_valid;
        cpu_req.addr  = cpu_mem_addr;
        cpu_req.wdata = cpu_mem_wdata;
        cpu_req.wstrb = cpu_mem_wstrb;
        dma_req.valid = dma_mem_valid;
        dma_req.addr  = dma_mem_addr;
        dma_req.wdata = dma_mem_wdata;
        dma_req.wstrb = dma_mem_wstrb;
    end

    mcu_subsys_rr_pick u_pick (
        .req   ({dma_mem_valid, cpu_mem_valid}),
        .last  (last_q),
        .grant (pick_grant)
    );

    assign gnt_req = sel_req(grant_q, cpu_req, dma_req);
    assign busy    = (state_q == ARB_BUSY);

    // Watchdog counts down from TIMEOUT_CYC-1; zero marks the last BUSY cycle allowed.
    assign wd_fire = (wd_cnt == '0);

    // Completions are suppressed while rst is high so an abandoned access never pulses ready.
    assign live       = busy && gnt_req.valid && !rst;
    assign done_ok    = live && sram_mem_ready;
    assign done_to    = live && !sram_mem_ready && wd_fire;
    assign done_rdata = done_ok ? sram_mem_rdata : ERR_RDATA;

    always_comb begin
        cpu_mem_ready = 1'b0;
        cpu_mem_rdata = '0;
        dma_mem_ready = 1'b0;
        dma_mem_rdata = '0;
        if (done_ok || done_to) begin
            if (grant_q == ARB_PORT_DMA) begin
                dma_mem_ready = 1'b1;
                dma_mem_rdata = done_rdata;
            end else begin
                cpu_mem_ready = 1'b1;
                cpu_mem_rdata = done_rdata;
            end
        end
    end

    assign timeout_err = done_to;

    assign sram_mem_valid = busy && gnt_req.valid;
    assign sram_mem_addr  = busy ? gnt_req.addr  : '0;
    assign sram_mem_wdata = busy ? gnt_req.wdata : '0;
    assign sram_mem_wstrb = busy ? gnt_req.wstrb : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= ARB_PORT_CPU;
            last_q  <= ARB_PORT_DMA;
            wd_cnt  <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (cpu_mem_valid || dma_mem_valid) begin
                        grant_q <= pick_grant;
                        wd_cnt  <= WD_LOAD;
                        state_q <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (!gnt_req.valid) begin
                        // Master withdrew its request: drop it without touching fairness history.
                        state_q <= ARB_IDLE;
                    end else if (sram_mem_ready || wd_fire) begin
                        last_q  <= grant_q;
                        state_q <= ARB_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_subsys_sram_arb.sv
// Bench for mcu_subsys_sram_arb: behavioural SRAM with programmable wait, bus-master
// tasks and a completion scoreboard checked on every falling edge.
module tb_mcu_subsys_sram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_mem_valid, cpu_mem_ready;
    logic [31:0] cpu_mem_addr, cpu_mem_wdata, cpu_mem_rdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        dma_mem_valid, dma_mem_ready;
    logic [31:0] dma_mem_addr, dma_mem_wdata, dma_mem_rdata;
    logic [3:0]  dma_mem_wstrb;
    logic        sram_mem_valid, sram_mem_ready;
    logic [31:0] sram_mem_addr, sram_mem_wdata, sram_mem_rdata;
    logic [3:0]  sram_mem_wstrb;
    logic        timeout_err;

    always #5 clk = ~clk;

    mcu_subsys_sram_arb #(.TIMEOUT_CYC(16), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_mem_valid  (cpu_mem_valid),
        .cpu_mem_ready  (cpu_mem_ready),
        .cpu_mem_addr   (cpu_mem_addr),
        .cpu_mem_wdata  (cpu_mem_wdata),
        .cpu_mem_wstrb  (cpu_mem_wstrb),
        .cpu_mem_rdata  (cpu_mem_rdata),
        .dma_mem_valid  (dma_mem_valid),
        .dma_mem_ready  (dma_mem_ready),
        .dma_mem_addr   (dma_mem_addr),
        .dma_mem_wdata  (dma_mem_wdata),
        .dma_mem_wstrb  (dma_mem_wstrb),
        .dma_mem_rdata  (dma_mem_rdata),
        .sram_mem_valid (sram_mem_valid),
        .sram_mem_ready (sram_mem_ready),
        .sram_mem_addr  (sram_mem_addr),
        .sram_mem_wdata (sram_mem_wdata),
        .sram_mem_wstrb (sram_mem_wstrb),
        .sram_mem_rdata (sram_mem_rdata),
        .timeout_err    (timeout_err)
    );

    // Behavioural SRAM: ready after sram_wait stalled cycles, rdata 0 on writes.
    logic [31:0] mem [0:255];
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;
    int          sram_wait;
    int          busy_cnt;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_data;
        end else if (sram_mem_valid && sram_mem_ready && sram_mem_wstrb != 4'b0) begin
            for (int b = 0; b < 4; b++)
                if (sram_mem_wstrb[b])
                    mem[sram_mem_addr[9:2]][8*b +: 8] <= sram_mem_wdata[8*b +: 8];
        end
        if (rst || !sram_mem_valid || sram_mem_ready) busy_cnt <= 0;
        else                                          busy_cnt <= busy_cnt + 1;
    end

    always_comb begin
        sram_mem_ready = sram_mem_valid && (busy_cnt >= sram_wait);
        sram_mem_rdata = (sram_mem_valid && sram_mem_wstrb == 4'b0) ? mem[sram_mem_addr[9:2]] : 32'h0;
    end

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          to;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        mon_port;
    logic [31:0] mon_rdata, mon_other;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic push_exp(input bit p, input logic [31:0] d, input bit to);
        exp_t e;
        e.port = p; e.rdata = d; e.to = to;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit p, input logic v, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws);
        if (p) begin
            dma_mem_valid = v; dma_mem_addr = a; dma_mem_wdata = wd; dma_mem_wstrb = ws;
        end else begin
            cpu_mem_valid = v; cpu_mem_addr = a; cpu_mem_wdata = wd; cpu_mem_wstrb = ws;
        end
    endtask

    // Hold a request until ready; lat = falling edges after issue (-1 if none within budget).
    task automatic access(input bit p, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input bit drop, output int lat);
        drive(p, 1'b1, a, wd, ws);
        lat = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if ((p ? dma_mem_ready : cpu_mem_ready) === 1'b1) begin
                lat = k;
                break;
            end
        end
        @(posedge clk); #1;
        if (drop) drive(p, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_idx = a[9:2]; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        sram_wait = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b1, 32'h0000_03FC, 32'hFFFF_FFFF, 4'hF);
        drive(1'b1, 1'b1, 32'h0000_03F8, 32'hFFFF_FFFF, 4'hF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({sram_mem_valid, sram_mem_addr, sram_mem_wdata, sram_mem_wstrb} !== 69'h0)
            $display("FAIL reset_sram_outs: valid=%b addr=%h wdata=%h wstrb=%b want all 0",
                     sram_mem_valid, sram_mem_addr, sram_mem_wdata, sram_mem_wstrb);
        else n_pass++;
        n_checks++;
        if ({cpu_mem_ready, dma_mem_ready, timeout_err, cpu_mem_rdata, dma_mem_rdata} !== 67'h0)
            $display("FAIL reset_port_outs: cpu_rdy=%b dma_rdy=%b err=%b cpu_rd=%h dma_rd=%h want 0",
                     cpu_mem_ready, dma_mem_ready, timeout_err, cpu_mem_rdata, dma_mem_rdata);
        else n_pass++;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({sram_mem_valid, sram_mem_wstrb, cpu_mem_ready, dma_mem_ready, timeout_err} !== 8'h0)
            $display("FAIL idle_after_reset: sram_valid=%b wstrb=%b cpu_rdy=%b dma_rdy=%b err=%b want 0",
                     sram_mem_valid, sram_mem_wstrb, cpu_mem_ready, dma_mem_ready, timeout_err);
        else n_pass++;
    endtask

    task automatic test_cpu_read();
        int lat;
        do_reset();
        preload(32'h0000_0100, 32'h1234_5678);
        push_exp(1'b0, 32'h1234_5678, 1'b0);
        access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b1, lat);
        n_checks++;
        if (lat !== 1) $display("FAIL cpu_read_latency: got %0d want 1", lat);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL cpu_read_drain: %0d expected completions left, want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_alternate();
        int lc, ld;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            preload(32'h0000_0200 + 32'(4*i), 32'hC000_0000 + 32'(i));
            preload(32'h0000_0300 + 32'(4*i), 32'hD000_0000 + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b0, 32'hC000_0000 + 32'(i), 1'b0);
            push_exp(1'b1, 32'hD000_0000 + 32'(i), 1'b0);
        end
        fork
            for (int i = 0; i < 4; i++)
                access(1'b0, 32'h0000_0200 + 32'(4*i), 32'h0, 4'h0, i == 3, lc);
            for (int j = 0; j < 4; j++)
                access(1'b1, 32'h0000_0300 + 32'(4*j), 32'h0, 4'h0, j == 3, ld);
        join
        n_checks++;
        if (lc < 0 || ld < 0) $display("FAIL alternate_timeout: cpu_lat=%0d dma_lat=%0d want both >=0", lc, ld);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL alternate_drain: %0d expected completions left, want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_dma_write();
        int lat;
        do_reset();
        preload(32'h0000_0080, 32'h1122_3344);
        push_exp(1'b1, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 32'h0000_0080, 32'hAABB_CCDD, 4'b0011);
        @(negedge clk);
        n_checks++;
        if (sram_mem_valid !== 1'b0 || sram_mem_wstrb !== 4'b0000)
            $display("FAIL dma_write_idle_strobe: valid=%b wstrb=%b want 0/0000", sram_mem_valid, sram_mem_wstrb);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({sram_mem_valid, sram_mem_addr, sram_mem_wdata, sram_mem_wstrb} !== {1'b1, 32'h80, 32'hAABB_CCDD, 4'b0011})
            $display("FAIL dma_write_busy_fwd: valid=%b addr=%h wdata=%h wstrb=%b want 1/00000080/aabbccdd/0011",
                     sram_mem_valid, sram_mem_addr, sram_mem_wdata, sram_mem_wstrb);
        else n_pass++;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        n_checks++;
        if (sram_mem_wstrb !== 4'b0000) $display("FAIL dma_write_after_strobe: wstrb=%b want 0000", sram_mem_wstrb);
        else n_pass++;
        @(posedge clk); #1;
        push_exp(1'b0, 32'h1122_CCDD, 1'b0);
        access(1'b0, 32'h0000_0080, 32'h0, 4'h0, 1'b1, lat);
        n_checks++;
        if (lat !== 1) $display("FAIL dma_write_readback_latency: got %0d want 1", lat);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int lat;
        do_reset();
        preload(32'h0000_0180, 32'h0BAD_F00D);
        sram_wait = 1000;
        push_exp(1'b0, 32'hDEAD_BEEF, 1'b1);
        access(1'b0, 32'h0000_0180, 32'h0, 4'h0, 1'b1, lat);
        n_checks++;
        if (lat !== 16) $display("FAIL timeout_latency: got %0d want 16", lat);
        else n_pass++;
        sram_wait = 15;
        push_exp(1'b0, 32'h0BAD_F00D, 1'b0);
        access(1'b0, 32'h0000_0180, 32'h0, 4'h0, 1'b1, lat);
        n_checks++;
        if (lat !== 16) $display("FAIL timeout_race_latency: got %0d want 16", lat);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL timeout_drain: %0d expected completions left, want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        do_reset();
        drive(1'b0, 1'b1, 32'h0000_0040, 32'h5555_AAAA, 4'hF);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cpu_mem_ready !== 1'b0 || timeout_err !== 1'b0)
            $display("FAIL reset_mid_ready: cpu_rdy=%b err=%b want 0/0", cpu_mem_ready, timeout_err);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({sram_mem_valid, sram_mem_addr, sram_mem_wdata, sram_mem_wstrb, cpu_mem_ready} !== 70'h0)
            $display("FAIL reset_mid_sram: valid=%b addr=%h wdata=%h wstrb=%b cpu_rdy=%b want all 0",
                     sram_mem_valid, sram_mem_addr, sram_mem_wdata, sram_mem_wstrb, cpu_mem_ready);
        else n_pass++;
        push_exp(1'b0, 32'h0, 1'b0);
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cpu_mem_ready === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat !== 0) $display("FAIL reset_mid_reissue: ready after %0d more edges, want 0", lat);
        else n_pass++;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_valid_drop();
        int lat, lc, ld;
        do_reset();
        preload(32'h0000_0100, 32'h1234_5678);
        preload(32'h0000_0104, 32'h0104_0104);
        preload(32'h0000_0088, 32'h7777_0001);
        preload(32'h0000_008C, 32'h7777_0002);
        sram_wait = 3;
        drive(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 32'h0000_0088, 32'h0, 4'h0);
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (sram_mem_valid !== 1'b1 || sram_mem_addr !== 32'h0000_0100)
            $display("FAIL drop_cpu_granted: valid=%b addr=%h want 1/00000100", sram_mem_valid, sram_mem_addr);
        else n_pass++;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        sram_wait = 0;
        @(negedge clk);
        n_checks++;
        if (sram_mem_valid !== 1'b0 || cpu_mem_ready !== 1'b0)
            $display("FAIL drop_follow: sram_valid=%b cpu_rdy=%b want 0/0", sram_mem_valid, cpu_mem_ready);
        else n_pass++;
        push_exp(1'b1, 32'h7777_0001, 1'b0);
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dma_mem_ready === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat !== 1) $display("FAIL drop_dma_next: latency %0d want 1", lat);
        else n_pass++;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        // A withdrawn grant leaves the tie-break with CPU (DMA completed last).
        sram_wait = 3;
        drive(1'b0, 1'b1, 32'h0000_0104, 32'h0, 4'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 32'h0000_008C, 32'h0, 4'h0);
        sram_wait = 0;
        @(posedge clk); #1;
        push_exp(1'b0, 32'h0104_0104, 1'b0);
        push_exp(1'b1, 32'h7777_0002, 1'b0);
        fork
            access(1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b1, lc);
            access(1'b1, 32'h0000_008C, 32'h0, 4'h0, 1'b1, ld);
        join
        n_checks++;
        if (lc !== 1 || ld !== 3) $display("FAIL drop_tie_break: cpu_lat=%0d dma_lat=%0d want 1/3", lc, ld);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL drop_drain: %0d expected completions left, want 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        rst       = 1'b1;
        pre_en    = 1'b0;
        pre_idx   = 8'h0;
        pre_data  = 32'h0;
        sram_wait = 0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

        fork
            forever begin
                @(negedge clk);
                if (cpu_mem_ready || dma_mem_ready) begin
                    n_checks++;
                    mon_port  = dma_mem_ready;
                    mon_rdata = dma_mem_ready ? dma_mem_rdata : cpu_mem_rdata;
                    mon_other = dma_mem_ready ? cpu_mem_rdata : dma_mem_rdata;
                    if (rst) begin
                        $display("FAIL ready_in_reset: cpu_rdy=%b dma_rdy=%b want 0/0", cpu_mem_ready, dma_mem_ready);
                    end else if (cpu_mem_ready && dma_mem_ready) begin
                        $display("FAIL dual_ready: both ports ready in one cycle, want one");
                    end else if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_completion: port=%0d rdata=%h, none expected", mon_port, mon_rdata);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_port !== mon_e.port || mon_rdata !== mon_e.rdata ||
                            timeout_err !== mon_e.to || mon_other !== 32'h0)
                            $display("FAIL scoreboard: port=%0d rdata=%h err=%b other_rdata=%h want port=%0d rdata=%h err=%b other_rdata=0",
                                     mon_port, mon_rdata, timeout_err, mon_other, mon_e.port, mon_e.rdata, mon_e.to);
                        else n_pass++;
                    end
                end else if (timeout_err) begin
                    n_checks++;
                    $display("FAIL lone_timeout_err: timeout_err=1 without a ready pulse");
                end
            end
        join_none

        test_reset();
        test_cpu_read();
        test_alternate();
        test_dma_write();
        test_timeout();
        test_reset_mid();
        test_valid_drop();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1, "bench did not finish");
    end

endmodule
